// File: rtl/cla_seq_multiplier_pkg.sv
// Shared constants and state type for the sequential CLA shift-and-add multiplier.
package cla_seq_multiplier_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned MUL_WIDTH = 16;
  localparam int unsigned MUL_ITERS = 16;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } mul_state_e;

endpackage

// File: rtl/cla16x16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second-level group lookahead.
module cla16x16
  import cla_seq_multiplier_pkg::*;
(
  input  logic [MUL_WIDTH-1:0] a_i,
  input  logic [MUL_WIDTH-1:0] b_i,
  input  logic                 cin_i,
  output logic [MUL_WIDTH-1:0] sum_o,
  output logic                 cout_o
);

  logic [15:0] g, p;
  logic [3:0]  gg, pg;
  logic        gc1, gc2, gc3, gc4;
  logic [3:0]  gcin;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    gg = '0;
    pg = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
  end

  // Group carries fully expanded so no carry ripples between groups.
  assign gc1 = gg[0] | (pg[0] & cin_i);
  assign gc2 = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin_i);
  assign gc3 = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) |
               (pg[2] & pg[1] & pg[0] & cin_i);
  assign gc4 = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) |
               (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & cin_i);
  assign gcin = {gc3, gc2, gc1, cin_i};
  assign cout_o = gc4;

  always_comb begin
    logic c;
    sum_o = '0;
    c     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c = gcin[k];
      for (int j = 0; j < 4; j++) begin
        sum_o[4*k+j] = p[4*k+j] ^ c;
        c            = g[4*k+j] | (p[4*k+j] & c);
      end
    end
  end

endmodule

// File: rtl/cla_seq_multiplier.sv
// Sequential 16x16 unsigned shift-and-add multiplier reusing one cla16x16 per iteration.
// Optional ZERO_SKIP_EN: a zero operand goes straight to DONE with product 0.
module cla_seq_multiplier
  import cla_seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] out_product_o,
  output logic               busy_o
);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign addend = mplr_q[0] ? mcand_q : '0;

  cla16x16 u_adder (
    .a_i   (acc_q),
    .b_i   (addend),
    .cin_i (1'b0),
    .sum_o (sum),
    .cout_o(cout)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          mcand_d = in_a_i;
          mplr_d  = in_b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
`ifdef ZERO_SKIP_EN
          if (in_a_i == '0 || in_b_i == '0) begin
            mplr_d  = '0;
            state_d = StDone;
          end
`endif
        end
      end
      StRun: begin
        // Carry-out lands in acc's MSB: a 33-bit right shift of {cout, sum, mplr}.
        {acc_d, mplr_d} = {cout, sum, mplr_q[WIDTH-1:1]};
        cnt_d           = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o    = (state_q == StIdle);
  assign out_valid_o   = (state_q == StDone);
  assign busy_o        = (state_q != StIdle);
  assign out_product_o = {acc_q, mplr_q};

endmodule

// File: tb/tb_cla_seq_multiplier.sv
// Self-checking bench for cla_seq_multiplier: latency/queue model plus directed literal vectors.
module tb_cla_seq_multiplier;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_a_i;
  logic [15:0] in_b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_product_o;
  logic        busy_o;

`ifdef ZERO_SKIP_EN
  localparam int ZeroLat = 1;
`else
  localparam int ZeroLat = 17;
`endif
  localparam int NRand = 1500;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          due = 0;
  int          n_out = 0;
  bit          pending = 1'b0;
  logic        exp_valid;
  logic [31:0] exp_q[$];

  cla_seq_multiplier dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_a_i       (in_a_i),
    .in_b_i       (in_b_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_product_o(out_product_o),
    .busy_o       (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Edges from accept to out_valid visible.
  function automatic int lat_edges(input logic [15:0] a, input logic [15:0] b);
`ifdef ZERO_SKIP_EN
    if (a == 16'd0 || b == 16'd0) return 0;
`endif
    return 16;
  endfunction

  // Reference model: one op in flight, product a*b due a fixed number of edges after accept.
  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      pending = 1'b0;
      exp_q.delete();
    end else begin
      exp_valid = pending && (cyc >= due);
      chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
      chk("in_ready", 64'(in_ready_o), 64'(!pending));
      chk("busy", 64'(busy_o), 64'(pending));
      if (exp_valid) begin
        chk("have_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) chk("product", 64'(out_product_o), 64'(exp_q[0]));
      end
      if (out_valid_o && out_ready_i) begin
        pending = 1'b0;
        n_out++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_valid_i && in_ready_o) begin
        pending = 1'b1;
        due     = cyc + 1 + lat_edges(in_a_i, in_b_i);
        exp_q.push_back(32'(in_a_i) * 32'(in_b_i));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_o && n < 100) begin
      step();
      n++;
    end
    chk("wait_ready", 64'(in_ready_o), 64'(1));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid_o && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_wait_valid"}, 64'(out_valid_o), 64'(1));
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p,
                        input int exp_cyc, input string tag);
    int lat;
    wait_ready();
    in_valid_i  = 1'b1;
    in_a_i      = a;
    in_b_i      = b;
    out_ready_i = 1'b0;
    step();
    in_valid_i = 1'b0;
    in_a_i     = 16'($urandom);
    in_b_i     = 16'($urandom);
    lat        = 1;
    while (!out_valid_o && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_cyc));
    chk({tag, "_product"}, 64'(out_product_o), 64'(exp_p));
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    int r = $urandom_range(0, 9);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  initial begin
    bit saw_valid;
    bit accepted;
    int n;
    int out_base;

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_a_i      = '0;
    in_b_i      = '0;
    out_ready_i = 1'b0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready_o), 64'(1));
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_product", 64'(out_product_o), 64'(0));
    rst_i = 1'b0;
    step();

    run_op(16'd3, 16'd5, 32'h0000_000F, 17, "basic");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, "max");
    run_op(16'h8000, 16'h0002, 32'h0001_0000, 17, "carry");
    run_op(16'h0000, 16'h1234, 32'h0000_0000, ZeroLat, "zero_a");
    run_op(16'h1234, 16'h0001, 32'h0000_1234, 17, "one");

    // Backpressure: operands presented during DONE must be ignored.
    wait_ready();
    in_valid_i = 1'b1;
    in_a_i     = 16'h00AB;
    in_b_i     = 16'h0100;
    step();
    in_a_i = 16'h1111;
    in_b_i = 16'h0003;
    wait_valid("bp");
    chk("bp_product", 64'(out_product_o), 64'h0000_AB00);
    repeat (5) begin
      step();
      chk("bp_hold_product", 64'(out_product_o), 64'h0000_AB00);
      chk("bp_hold_in_ready", 64'(in_ready_o), 64'(0));
      chk("bp_hold_busy", 64'(busy_o), 64'(1));
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk("bp_idle_in_ready", 64'(in_ready_o), 64'(1));
    step();
    chk("bp_next_accept_busy", 64'(busy_o), 64'(1));
    in_valid_i = 1'b0;
    wait_valid("bp_next");
    chk("bp_next_product", 64'(out_product_o), 64'h0000_3333);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;

    // Reset in the middle of RUN aborts the operation.
    wait_ready();
    in_valid_i = 1'b1;
    in_a_i     = 16'h1234;
    in_b_i     = 16'h5678;
    step();
    in_valid_i = 1'b0;
    repeat (8) step();
    rst_i = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready_o), 64'(1));
    chk("abort_product", 64'(out_product_o), 64'(0));
    chk("abort_busy", 64'(busy_o), 64'(0));
    step();
    rst_i     = 1'b0;
    saw_valid = 1'b0;
    out_ready_i = 1'b1;
    repeat (20) begin
      step();
      if (out_valid_o) saw_valid = 1'b1;
    end
    out_ready_i = 1'b0;
    chk("abort_no_valid", 64'(saw_valid), 64'(0));
    run_op(16'd7, 16'd9, 32'd63, 17, "after_rst");

    // Back-to-back random operands with random output stalls.
    out_base = n_out;
    for (int i = 0; i < NRand; i++) begin
      in_valid_i = 1'b1;
      in_a_i     = pick();
      in_b_i     = pick();
      accepted   = 1'b0;
      n          = 0;
      while (!accepted && n < 100) begin
        out_ready_i = ($urandom_range(0, 3) != 0);
        if (in_ready_o) accepted = 1'b1;
        step();
        n++;
      end
      if (!accepted) chk("rand_accept", 64'(accepted), 64'(1));
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    n = 0;
    while (busy_o && n < 100) begin
      step();
      n++;
    end
    chk("rand_drained", 64'(busy_o), 64'(0));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("rand_output_count", 64'(n_out - out_base), 64'(NRand));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
